// File: rtl/circle_raster_pkg.sv
// Shared types and defaults for the circle rasteriser.
// Holds width defaults, FSM state encoding and draw mode encoding.
package circle_raster_pkg;

   localparam int DEF_WIDTH_BITS   = 10;
   localparam int DEF_HEIGHT_BITS  = 9;
   localparam int DEF_CHANNEL_BITS = 8;
   localparam int DEF_SCREEN_W     = 640;
   localparam int DEF_SCREEN_H     = 480;

   localparam logic MODE_FILLED  = 1'b0;
   localparam logic MODE_OUTLINE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROW_INIT,
      ST_SPAN_SEARCH,
      ST_EMIT,
      ST_FIN
   } state_t;

endpackage

// File: rtl/circle_span_gen.sv
// Incremental half-width search: tracks h(a) and h(a+1) with two
// pointers that step by one per cycle until both settle.
module circle_span_gen #(
   parameter int W = 10
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               clr,
   input  logic               req,
   input  logic signed [W+1:0] a,
   input  logic [W-1:0]       rad,
   output logic               span_valid,
   output logic signed [W+1:0] h,
   output logic signed [W+1:0] k
);

   localparam int CW = W + 2;
   localparam int SW = 2 * W + 2;
   localparam logic signed [CW-1:0] C_ONE = CW'(1);
   localparam logic signed [CW-1:0] C_NEG = '1;

   logic signed [CW-1:0] pa, pb, tgt, sa, sb, pa_m1;
   logic signed [SW-1:0] r2, ta2, tb2;
   logic                 run;

   function automatic logic signed [SW-1:0] sq(
      input logic signed [CW-1:0] v
   );
      logic signed [SW-1:0] e;
      e = {{(SW-CW){v[CW-1]}}, v};
      return e * e;
   endfunction

   // -1 to shrink, +1 to grow, 0 once p is the largest dx inside
   function automatic logic signed [CW-1:0] step(
      input logic signed [CW-1:0] p,
      input logic signed [SW-1:0] t2,
      input logic signed [SW-1:0] rr
   );
      if (!p[CW-1] && (sq(p) + t2 > rr))
         return C_NEG;
      else if (sq(p + C_ONE) + t2 <= rr)
         return C_ONE;
      return '0;
   endfunction

   assign r2  = sq($signed({2'b00, rad}));
   assign ta2 = sq(tgt);
   assign tb2 = sq(tgt + C_ONE);
   assign sa  = step(pa, ta2, r2);
   assign sb  = step(pb, tb2, r2);

   assign span_valid = run && (sa == '0) && (sb == '0);
   assign pa_m1      = pa - C_ONE;
   assign h          = pa;
   assign k          = (pb < pa_m1) ? pb : pa_m1;

   always_ff @(posedge clk) begin
      if (!n_rst || clr) begin
         run <= 1'b0;
         pa  <= C_NEG;
         pb  <= C_NEG;
         tgt <= '0;
      end else if (req) begin
         run <= 1'b1;
         tgt <= a;
      end else if (run) begin
         if (span_valid)
            run <= 1'b0;
         pa <= pa + sa;
         pb <= pb + sb;
      end
   end

endmodule

// File: rtl/circle_raster.sv
// Filled/outline circle rasteriser with screen clipping and a
// valid/ready pixel stream in row-major order.
module circle_raster
   import circle_raster_pkg::*;
#(
   parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
   parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
   parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic                    mode,
   input  logic                    abort,
   input  logic [WIDTH_BITS-1:0]   xC,
   input  logic [HEIGHT_BITS-1:0]  yC,
   input  logic [WIDTH_BITS-1:0]   rad,
   input  logic [CHANNEL_BITS-1:0] r_i,
   input  logic [CHANNEL_BITS-1:0] g_i,
   input  logic [CHANNEL_BITS-1:0] b_i,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   input  logic                    ready,
   output logic [WIDTH_BITS-1:0]   X,
   output logic [HEIGHT_BITS-1:0]  Y,
   output logic [CHANNEL_BITS-1:0] r_o,
   output logic [CHANNEL_BITS-1:0] g_o,
   output logic [CHANNEL_BITS-1:0] b_o
);

   localparam int CW = WIDTH_BITS + 2;
   localparam logic signed [CW-1:0] XMAX  = CW'(SCREEN_W - 1);
   localparam logic signed [CW-1:0] YLIM  = CW'(SCREEN_H);
   localparam logic signed [CW-1:0] C_ONE = CW'(1);

   state_t state, nstate;

   logic [WIDTH_BITS-1:0]  xc_q, rad_q, hi_q, lo2_q, hi2_q;
   logic [HEIGHT_BITS-1:0] yc_q;
   logic                   mode_q, pend2_q;

   logic signed [CW-1:0] dy, ady, y_row, xc_s, rad_s, h, k;
   logic signed [CW-1:0] l1, h1, l2, h2, c_l1, c_h1, c_l2, c_h2;
   logic span_valid, filled_like, row_on, has1, has2;
   logic last_row, accept, kill, xfer, seg_end, req;

   assign xc_s  = $signed({2'b00, xc_q});
   assign rad_s = $signed({2'b00, rad_q});
   assign y_row = $signed({{(CW-HEIGHT_BITS){1'b0}}, yc_q}) + dy;
   assign ady   = dy[CW-1] ? -dy : dy;

   circle_span_gen #(
      .W(WIDTH_BITS)
   ) u_span (
      .clk       (clk),
      .n_rst     (n_rst),
      .clr       (accept || kill),
      .req       (req),
      .a         (ady),
      .rad       (rad_q),
      .span_valid(span_valid),
      .h         (h),
      .k         (k)
   );

   // k < 0 means the inner gap is empty, so the row is one solid span
   assign filled_like = (mode_q == MODE_FILLED) || k[CW-1];
   assign l1 = xc_s - h;
   assign h1 = filled_like ? xc_s + h : xc_s - k - C_ONE;
   assign l2 = xc_s + k + C_ONE;
   assign h2 = xc_s + h;

   assign c_l1 = l1[CW-1] ? '0 : l1;
   assign c_h1 = (h1 > XMAX) ? XMAX : h1;
   assign c_l2 = l2[CW-1] ? '0 : l2;
   assign c_h2 = (h2 > XMAX) ? XMAX : h2;

   assign row_on = !y_row[CW-1] && (y_row < YLIM);
   assign has1   = row_on && (c_l1 <= c_h1);
   assign has2   = row_on && !filled_like && (c_l2 <= c_h2);

   assign last_row = (dy == rad_s);
   assign seg_end  = (X == hi_q);

   always_ff @(posedge clk) begin
      if (!n_rst)
         state <= ST_IDLE;
      else
         state <= nstate;
   end

   always_comb begin
      nstate = state;
      valid  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      req    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start)
               nstate = ST_ROW_INIT;
         end
         ST_ROW_INIT: begin
            busy   = 1'b1;
            req    = 1'b1;
            nstate = ST_SPAN_SEARCH;
         end
         ST_SPAN_SEARCH: begin
            busy = 1'b1;
            if (span_valid) begin
               if (has1 || has2)
                  nstate = ST_EMIT;
               else if (last_row)
                  nstate = ST_FIN;
               else
                  nstate = ST_ROW_INIT;
            end
         end
         ST_EMIT: begin
            busy  = 1'b1;
            valid = 1'b1;
            if (ready && seg_end && !pend2_q)
               nstate = last_row ? ST_FIN : ST_ROW_INIT;
         end
         ST_FIN: begin
            done   = 1'b1;
            nstate = start ? ST_ROW_INIT : ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
      if (abort && busy)
         nstate = ST_IDLE;
   end

   assign accept = start && ((state == ST_IDLE) || (state == ST_FIN));
   assign kill   = abort && busy;
   assign xfer   = valid && ready && !abort;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         xc_q    <= '0;
         yc_q    <= '0;
         rad_q   <= '0;
         mode_q  <= 1'b0;
         dy      <= '0;
         X       <= '0;
         Y       <= '0;
         hi_q    <= '0;
         lo2_q   <= '0;
         hi2_q   <= '0;
         pend2_q <= 1'b0;
         r_o     <= '0;
         g_o     <= '0;
         b_o     <= '0;
      end else begin
         if (accept) begin
            xc_q   <= xC;
            yc_q   <= yC;
            rad_q  <= rad;
            mode_q <= mode;
            dy     <= -$signed({2'b00, rad});
            r_o    <= r_i;
            g_o    <= g_i;
            b_o    <= b_i;
         end
         if ((state == ST_SPAN_SEARCH) && span_valid) begin
            if (has1) begin
               X       <= c_l1[WIDTH_BITS-1:0];
               hi_q    <= c_h1[WIDTH_BITS-1:0];
               lo2_q   <= c_l2[WIDTH_BITS-1:0];
               hi2_q   <= c_h2[WIDTH_BITS-1:0];
               pend2_q <= has2;
               Y       <= y_row[HEIGHT_BITS-1:0];
            end else if (has2) begin
               X       <= c_l2[WIDTH_BITS-1:0];
               hi_q    <= c_h2[WIDTH_BITS-1:0];
               pend2_q <= 1'b0;
               Y       <= y_row[HEIGHT_BITS-1:0];
            end else begin
               dy <= dy + C_ONE;
            end
         end
         if (xfer) begin
            if (!seg_end) begin
               X <= X + 1'b1;
            end else if (pend2_q) begin
               X       <= lo2_q;
               hi_q    <= hi2_q;
               pend2_q <= 1'b0;
            end else begin
               dy <= dy + C_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_circle_raster.sv
// Directed bench for circle_raster: hand-computed pixel lists,
// stalls, clipping, empty draw and abort.
module tb_circle_raster;
   import circle_raster_pkg::*;

   logic       tb_clk = 1'b0;
   logic       n_rst, start, mode, abort, ready;
   logic [9:0] xC, rad, X;
   logic [8:0] yC, Y;
   logic [7:0] r_i, g_i, b_i, r_o, g_o, b_o;
   logic       busy, done, valid;

   int         checks = 0;
   int         fails  = 0;
   int         got_x[64];
   int         got_y[64];
   int         n_px, done_at, last_at, col_err, xf, dn;
   logic [15:0] lfsr;

   int e2x[13] = '{10, 9, 10, 11, 8, 9, 10, 11, 12, 9, 10, 11, 10};
   int e2y[13] = '{8, 9, 9, 9, 10, 10, 10, 10, 10, 11, 11, 11, 12};
   int e3x[8]  = '{10, 9, 11, 8, 12, 9, 11, 10};
   int e3y[8]  = '{8, 9, 9, 10, 10, 11, 11, 12};
   int e4x[6]  = '{0, 1, 2, 0, 1, 0};
   int e4y[6]  = '{0, 0, 0, 1, 1, 2};
   int e7x[4]  = '{5, 4, 6, 5};
   int e7y[4]  = '{5, 6, 6, 7};

   circle_raster dut (
      .clk  (tb_clk),
      .n_rst(n_rst),
      .start(start),
      .mode (mode),
      .abort(abort),
      .xC   (xC),
      .yC   (yC),
      .rad  (rad),
      .r_i  (r_i),
      .g_i  (g_i),
      .b_i  (b_i),
      .busy (busy),
      .done (done),
      .valid(valid),
      .ready(ready),
      .X    (X),
      .Y    (Y),
      .r_o  (r_o),
      .g_o  (g_o),
      .b_o  (b_o)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_draw(input int x, input int y, input int r,
                           input logic m, input logic rnd,
                           input int limit, input logic [23:0] col);
      logic stall;
      int   sx, sy;
      n_px = 0; done_at = 0; last_at = 0; col_err = 0;
      stall = 1'b0; sx = 0; sy = 0;
      @(negedge tb_clk);
      xC = x[9:0]; yC = y[8:0]; rad = r[9:0]; mode = m;
      {r_i, g_i, b_i} = col;
      start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (rnd) begin
            lfsr  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            ready = lfsr[0];
         end else begin
            ready = 1'b1;
         end
         if (stall) begin
            check("stall_valid", int'(valid), 1);
            check("stall_x", int'(X), sx);
            check("stall_y", int'(Y), sy);
         end
         if (done) begin
            done_at = cyc;
            break;
         end
         if (valid && ready) begin
            if (n_px < 64) begin
               got_x[n_px] = int'(X);
               got_y[n_px] = int'(Y);
            end
            if ({r_o, g_o, b_o} != col)
               col_err++;
            n_px++;
            last_at = cyc;
         end
         stall = valid && !ready;
         sx = int'(X);
         sy = int'(Y);
         @(negedge tb_clk);
      end
      ready = 1'b1;
      check("done_seen", int'(done_at > 0), 1);
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; mode = MODE_FILLED; abort = 1'b0;
      ready = 1'b1; xC = '0; yC = '0; rad = '0;
      r_i = '0; g_i = '0; b_i = '0;
      lfsr = 16'hACE1;
      repeat (3) @(negedge tb_clk);
      check("rst_valid", int'(valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_x", int'(X), 0);
      check("rst_y", int'(Y), 0);
      check("rst_rgb", int'({r_o, g_o, b_o}), 0);
      n_rst = 1'b1;

      run_draw(320, 240, 0, MODE_FILLED, 1'b0, 200, 24'hFFFFFF);
      check("t1_n", n_px, 1);
      check("t1_x", got_x[0], 320);
      check("t1_y", got_y[0], 240);
      check("t1_done_lat", done_at - last_at, 1);
      check("t1_col", col_err, 0);

      run_draw(10, 10, 2, MODE_FILLED, 1'b0, 200, 24'h010203);
      check("t2_n", n_px, 13);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("t2_x%0d", i), got_x[i], e2x[i]);
         check($sformatf("t2_y%0d", i), got_y[i], e2y[i]);
      end
      check("t2_done_lat", done_at - last_at, 1);
      check("t2_budget", int'(done_at <= 51), 1);
      check("t2_col", col_err, 0);

      run_draw(10, 10, 2, MODE_OUTLINE, 1'b0, 200, 24'h00FF00);
      check("t3_n", n_px, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t3_x%0d", i), got_x[i], e3x[i]);
         check($sformatf("t3_y%0d", i), got_y[i], e3y[i]);
      end
      check("t3_done_lat", done_at - last_at, 1);

      run_draw(0, 0, 2, MODE_FILLED, 1'b0, 200, 24'h123456);
      check("t4_n", n_px, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t4_x%0d", i), got_x[i], e4x[i]);
         check($sformatf("t4_y%0d", i), got_y[i], e4y[i]);
      end
      check("t4_done_lat", done_at - last_at, 1);

      run_draw(10, 10, 2, MODE_FILLED, 1'b1, 600, 24'h0A0B0C);
      check("t5_n", n_px, 13);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("t5_x%0d", i), got_x[i], e2x[i]);
         check($sformatf("t5_y%0d", i), got_y[i], e2y[i]);
      end
      check("t5_col", col_err, 0);

      run_draw(700, 240, 10, MODE_FILLED, 1'b0, 300, 24'h808080);
      check("t6_n", n_px, 0);
      check("t6_budget", int'(done_at <= 134), 1);

      @(negedge tb_clk);
      xC = 10'd320; yC = 9'd240; rad = 10'd200; mode = MODE_FILLED;
      start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
      xf = 0;
      for (int c = 0; c < 2000 && xf < 3; c++) begin
         if (valid)
            xf++;
         @(negedge tb_clk);
      end
      check("ab_xfers", xf, 3);
      check("ab_valid_pre", int'(valid), 1);
      check("ab_busy_pre", int'(busy), 1);
      abort = 1'b1;
      @(negedge tb_clk);
      abort = 1'b0;
      check("ab_valid", int'(valid), 0);
      check("ab_busy", int'(busy), 0);
      check("ab_done", int'(done), 0);
      dn = 0;
      repeat (20) begin
         @(negedge tb_clk);
         if (done || valid)
            dn++;
      end
      check("ab_quiet", dn, 0);

      run_draw(5, 6, 1, MODE_OUTLINE, 1'b0, 200, 24'hC0FFEE);
      check("t7_n", n_px, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t7_x%0d", i), got_x[i], e7x[i]);
         check($sformatf("t7_y%0d", i), got_y[i], e7y[i]);
      end
      check("t7_col", col_err, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
